pupil_track_filter: RTL and testbench
=====================================

// Module: pupil_track_filter
// PURPOSE
//  Downstream of the column-projection pupil locator. Once per frame, takes its two candidate (x,y)
//  points and coords_valid. Sorts them into left/right eye, rejects implausible jumps, and smooths
//  each coordinate with a fixed-point IIR. A SEARCH/ACQUIRE/TRACK/HOLD FSM gates output validity
//  for the overlay/UART stage.
// PARAMETERS
//  IMG_HDISP    11'd1280  active width; sample invalid if either x >= IMG_HDISP
//  IMG_VDISP    11'd720   active height; sample invalid if either y >= IMG_VDISP
//  SAMPLE_DLY   4         cycles from frame_vsync falling edge to input sampling (1..15)
//  JUMP_TH      64        max |sample - filtered| per axis, integer pixels, to count as a hit
//  SHIFT        2         IIR gain = 2^-SHIFT (1..4)
//  ACQ_FRAMES   3         consecutive coherent hits to enter TRACK (2..7)
//  HOLD_FRAMES  8         consecutive misses (incl. the first) before dropping to SEARCH (1..15)
// PORTS
//  clk           in   1   pixel clock
//  rst_n         in   1   async active-low reset
//  frame_vsync   in   1   frame sync, same timing as locator's input vsync
//  x_max_1       in   11  candidate A column
//  x_max_2       in   11  candidate B column
//  y_max_1       in   16  candidate A row (mean)
//  y_max_2       in   16  candidate B row (mean)
//  coords_valid  in   1   locator validity flag
//  left_x        out  11  filtered left-eye column (smaller x)
//  left_y        out  10  filtered left-eye row
//  right_x       out  11  filtered right-eye column
//  right_y       out  10  filtered right-eye row
//  track_state   out  2   0=SEARCH 1=ACQUIRE 2=TRACK 3=HOLD
//  out_valid     out  1   1 in TRACK or HOLD
//  frame_done    out  1   1-cycle pulse when outputs update
// BEHAVIOUR
//  Reset: all outputs 0, state SEARCH, all counters 0, filters 0.
//  Sampling: register frame_vsync and detect its falling edge. The edge loads a down-counter with
//   SAMPLE_DLY. smp pulses on the cycle the counter reaches 0.
//   A new falling edge during countdown reloads the counter; no smp for the aborted count.
//   If an edge coincides with smp, smp is processed and the counter reloads.
//  Stage 1 (cycle after smp):
//   - Register the sorted sample: L = candidate with smaller x (tie: A); R = the other.
//     Each y keeps its low 10 bits.
//   - good = coords_valid & both x < IMG_HDISP & both y < IMG_VDISP.
//   - near = good & |sx-fx_int| <= JUMP_TH & |sy-fy_int| <= JUMP_TH, on all four axes
//     (L and R, x and y).
//  Stage 2 (2 cycles after smp): filter and FSM update registered; outputs and frame_done change.
//  Filter per axis, unsigned 4-fractional-bit accumulator (x 15b, y 14b):
//   - load: f = s<<4
//   - update: f = f + ((s<<4) - f) >>> SHIFT, signed difference, arithmetic shift (floor)
//   - output = f>>4; clear: f = 0
//  FSM, evaluated only at stage 2:
//   SEARCH : good -> load, acq=1, ACQUIRE; else stay, filters cleared
//   ACQUIRE: near -> update, acq+1; when acq+1 == ACQ_FRAMES -> TRACK
//            good&!near -> load, acq=1, stay; !good -> clear, SEARCH
//   TRACK  : near -> update, miss=0, stay; else -> HOLD, miss=1, filters frozen
//   HOLD   : near -> update, miss=0, TRACK; else miss+1; when miss+1 == HOLD_FRAMES -> clear, SEARCH
//   HOLD_FRAMES==1: a miss in TRACK goes directly to SEARCH (clear).
//  Outputs always equal filter integer parts (0 after clear). out_valid is combinational from state.
//  Counters saturate, never wrap. Reset asserted mid-frame or mid-pipeline aborts everything to reset values.
// TESTING
//  1 Reset, 3 vsync frames with coords_valid=0 -> state 0, outputs 0, frame_done pulses 3x, each 2 cyc after smp
//  2 3 frames A=(900,310) B=(400,300) valid -> left=(400,300) right=(900,310); state 1,1,2; out_valid=1 after 3rd
//  3 TRACK at left_x=400, then left_x sample 440 twice -> left_x 410 then 417; other axes unchanged
//  4 TRACK, then sample jumps left_x 400->600 -> state 3, outputs held;
//    7 further invalid frames -> state 0, outputs 0, out_valid 0 on that frame
//  5 HOLD after 2 misses, then near sample -> state 2, miss cleared, filter updated
//  6 coords_valid=1 with y_max_1=800 -> treated as miss; second vsync falling edge 2 cyc after first -> exactly one smp

Source files
------------

// File: rtl/pupil_track_filter.sv
// Per-frame pupil tracker: takes the locator's two candidates, sorts them into left/right eye,
// gates out implausible jumps, smooths each axis with a fixed-point IIR and tracks lock state.
module pupil_track_filter #(
  parameter logic [10:0] IMG_HDISP   = 11'd1280,
  parameter logic [10:0] IMG_VDISP   = 11'd720,
  parameter int          SAMPLE_DLY  = 4,
  parameter int          JUMP_TH     = 64,
  parameter int          SHIFT       = 2,
  parameter int          ACQ_FRAMES  = 3,
  parameter int          HOLD_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_vsync,
  input  logic [10:0] x_max_1,
  input  logic [10:0] x_max_2,
  input  logic [15:0] y_max_1,
  input  logic [15:0] y_max_2,
  input  logic        coords_valid,
  output logic [10:0] left_x,
  output logic [9:0]  left_y,
  output logic [10:0] right_x,
  output logic [9:0]  right_y,
  output logic [1:0]  track_state,
  output logic        out_valid,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  typedef enum logic [1:0] {F_KEEP, F_LOAD, F_UPDATE, F_CLEAR} fop_t;

  localparam logic [3:0] DLY_N  = 4'(SAMPLE_DLY);
  localparam logic [2:0] ACQ_N  = 3'(ACQ_FRAMES);
  localparam logic [3:0] HOLD_N = 4'(HOLD_FRAMES);

  // Accumulators carry 4 fractional bits; the integer part is the output.
  function automatic logic [14:0] iir_x(input logic [14:0] f, input logic [10:0] s);
    logic signed [15:0] diff;
    logic signed [15:0] sum;
    diff = $signed({1'b0, s, 4'b0000}) - $signed({1'b0, f});
    sum  = $signed({1'b0, f}) + (diff >>> SHIFT);
    return 15'(sum);
  endfunction

  function automatic logic [13:0] iir_y(input logic [13:0] f, input logic [9:0] s);
    logic signed [14:0] diff;
    logic signed [14:0] sum;
    diff = $signed({1'b0, s, 4'b0000}) - $signed({1'b0, f});
    sum  = $signed({1'b0, f}) + (diff >>> SHIFT);
    return 14'(sum);
  endfunction

  function automatic logic within_th(input logic [10:0] s, input logic [10:0] f);
    logic [11:0] d;
    d = (s >= f) ? ({1'b0, s} - {1'b0, f}) : ({1'b0, f} - {1'b0, s});
    return d <= 12'(JUMP_TH);
  endfunction

  // ---------------- sample strobe ----------------
  logic       vsync_q;
  logic [3:0] dly_cnt;
  logic       dly_busy;
  logic       vs_fall;
  logic       smp;

  assign vs_fall = vsync_q & ~frame_vsync;
  assign smp     = dly_busy & (dly_cnt == 4'd0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q  <= 1'b0;
      dly_cnt  <= 4'd0;
      dly_busy <= 1'b0;
    end else begin
      vsync_q <= frame_vsync;
      if (vs_fall) begin
        dly_cnt  <= DLY_N;
        dly_busy <= 1'b1;
      end else if (smp) begin
        dly_busy <= 1'b0;
      end else if (dly_busy) begin
        dly_cnt <= dly_cnt - 4'd1;
      end
    end
  end

  // ---------------- stage 1: sort and qualify ----------------
  logic [14:0] f_lx, f_rx;
  logic [13:0] f_ly, f_ry;

  logic        a_left;
  logic [10:0] lx_c, rx_c;
  logic [9:0]  ly_c, ry_c;
  logic        good_c, near_c;

  assign a_left = (x_max_1 <= x_max_2);
  assign lx_c   = a_left ? x_max_1 : x_max_2;
  assign rx_c   = a_left ? x_max_2 : x_max_1;
  assign ly_c   = a_left ? y_max_1[9:0] : y_max_2[9:0];
  assign ry_c   = a_left ? y_max_2[9:0] : y_max_1[9:0];

  assign good_c = coords_valid
                & (x_max_1 < IMG_HDISP) & (x_max_2 < IMG_HDISP)
                & (y_max_1 < {5'd0, IMG_VDISP}) & (y_max_2 < {5'd0, IMG_VDISP});

  assign near_c = good_c
                & within_th(lx_c, f_lx[14:4]) & within_th({1'b0, ly_c}, {1'b0, f_ly[13:4]})
                & within_th(rx_c, f_rx[14:4]) & within_th({1'b0, ry_c}, {1'b0, f_ry[13:4]});

  logic        s1_v, s1_good, s1_near;
  logic [10:0] s1_lx, s1_rx;
  logic [9:0]  s1_ly, s1_ry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_good <= 1'b0;
      s1_near <= 1'b0;
      s1_lx   <= '0;
      s1_rx   <= '0;
      s1_ly   <= '0;
      s1_ry   <= '0;
    end else begin
      s1_v <= smp;
      if (smp) begin
        s1_good <= good_c;
        s1_near <= near_c;
        s1_lx   <= lx_c;
        s1_rx   <= rx_c;
        s1_ly   <= ly_c;
        s1_ry   <= ry_c;
      end
    end
  end

  // ---------------- stage 2: FSM and filters ----------------
  state_t     state, state_n;
  logic [2:0] acq, acq_n, acq_inc;
  logic [3:0] miss, miss_n, miss_inc;
  fop_t       fop;

  assign acq_inc  = (acq == 3'd7)   ? acq  : acq + 3'd1;
  assign miss_inc = (miss == 4'd15) ? miss : miss + 4'd1;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n = state;
    acq_n   = acq;
    miss_n  = miss;
    fop     = F_KEEP;
    if (s1_v) begin
      unique case (state)
        ST_SEARCH: begin
          if (s1_good) begin
            fop     = F_LOAD;
            acq_n   = 3'd1;
            state_n = ST_ACQUIRE;
          end else begin
            fop    = F_CLEAR;
            acq_n  = 3'd0;
            miss_n = 4'd0;
          end
        end
        ST_ACQUIRE: begin
          if (s1_near) begin
            fop   = F_UPDATE;
            acq_n = acq_inc;
            if (acq_inc == ACQ_N) state_n = ST_TRACK;
          end else if (s1_good) begin
            fop   = F_LOAD;
            acq_n = 3'd1;
          end else begin
            fop     = F_CLEAR;
            acq_n   = 3'd0;
            state_n = ST_SEARCH;
          end
        end
        ST_TRACK: begin
          if (s1_near) begin
            fop    = F_UPDATE;
            miss_n = 4'd0;
          end else if (HOLD_FRAMES == 1) begin
            fop     = F_CLEAR;
            acq_n   = 3'd0;
            miss_n  = 4'd0;
            state_n = ST_SEARCH;
          end else begin
            miss_n  = 4'd1;
            state_n = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (s1_near) begin
            fop     = F_UPDATE;
            miss_n  = 4'd0;
            state_n = ST_TRACK;
          end else if (miss_inc == HOLD_N) begin
            fop     = F_CLEAR;
            acq_n   = 3'd0;
            miss_n  = 4'd0;
            state_n = ST_SEARCH;
          end else begin
            miss_n = miss_inc;
          end
        end
        default: state_n = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_SEARCH;
      acq        <= 3'd0;
      miss       <= 4'd0;
      frame_done <= 1'b0;
      f_lx       <= '0;
      f_rx       <= '0;
      f_ly       <= '0;
      f_ry       <= '0;
    end else begin
      state      <= state_n;
      acq        <= acq_n;
      miss       <= miss_n;
      frame_done <= s1_v;
      unique case (fop)
        F_LOAD: begin
          f_lx <= {s1_lx, 4'b0000};
          f_rx <= {s1_rx, 4'b0000};
          f_ly <= {s1_ly, 4'b0000};
          f_ry <= {s1_ry, 4'b0000};
        end
        F_UPDATE: begin
          f_lx <= iir_x(f_lx, s1_lx);
          f_rx <= iir_x(f_rx, s1_rx);
          f_ly <= iir_y(f_ly, s1_ly);
          f_ry <= iir_y(f_ry, s1_ry);
        end
        F_CLEAR: begin
          f_lx <= '0;
          f_rx <= '0;
          f_ly <= '0;
          f_ry <= '0;
        end
        default: ;
      endcase
    end
  end

  assign left_x      = f_lx[14:4];
  assign left_y      = f_ly[13:4];
  assign right_x     = f_rx[14:4];
  assign right_y     = f_ry[13:4];
  assign track_state = state;
  assign out_valid   = (state == ST_TRACK) | (state == ST_HOLD);

endmodule

// File: tb/tb_pupil_track_filter.sv
// Self-checking bench for pupil_track_filter: table of per-frame stimulus with hand-derived
// expected outputs, fed through a scoreboard queue that is drained on each frame_done pulse.
module tb_pupil_track_filter;

  localparam int SAMPLE_DLY = 4;
  localparam int LATENCY    = SAMPLE_DLY + 3;  // negedges from vsync drop to frame_done seen

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_vsync = 1'b0;
  logic [10:0] x_max_1 = '0, x_max_2 = '0;
  logic [15:0] y_max_1 = '0, y_max_2 = '0;
  logic        coords_valid = 1'b0;
  logic [10:0] left_x, right_x;
  logic [9:0]  left_y, right_y;
  logic [1:0]  track_state;
  logic        out_valid, frame_done;

  pupil_track_filter #(.SAMPLE_DLY(SAMPLE_DLY)) dut (
    .clk(clk), .rst_n(rst_n), .frame_vsync(frame_vsync),
    .x_max_1(x_max_1), .x_max_2(x_max_2), .y_max_1(y_max_1), .y_max_2(y_max_2),
    .coords_valid(coords_valid),
    .left_x(left_x), .left_y(left_y), .right_x(right_x), .right_y(right_y),
    .track_state(track_state), .out_valid(out_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] xa; logic [15:0] ya; logic [10:0] xb; logic [15:0] yb; logic v;
    logic [10:0] lx; logic [9:0] ly; logic [10:0] rx; logic [9:0] ry; logic [1:0] st;
  } vec_t;

  typedef struct {
    logic [10:0] lx; logic [9:0] ly; logic [10:0] rx; logic [9:0] ry; logic [1:0] st;
  } exp_t;

  vec_t vecs_a[$];
  vec_t vecs_b[$];
  exp_t sb_q[$];
  exp_t sb_e;
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input int xa, input int ya, input int xb, input int yb, input bit v,
                              input int lx, input int ly, input int rx, input int ry, input int st);
    vec_t r;
    r.xa = 11'(xa); r.ya = 16'(ya); r.xb = 11'(xb); r.yb = 16'(yb); r.v = v;
    r.lx = 11'(lx); r.ly = 10'(ly); r.rx = 11'(rx); r.ry = 10'(ry); r.st = 2'(st);
    return r;
  endfunction

  // Scoreboard consumer: every frame_done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && frame_done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        check("unexpected frame_done", 32'd1, 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        check("left_x",      32'(left_x),      32'(sb_e.lx));
        check("left_y",      32'(left_y),      32'(sb_e.ly));
        check("right_x",     32'(right_x),     32'(sb_e.rx));
        check("right_y",     32'(right_y),     32'(sb_e.ry));
        check("track_state", 32'(track_state), 32'(sb_e.st));
        check("out_valid",   32'(out_valid),   32'(sb_e.st >= 2'd2));
      end
    end
  end

  task automatic drive_frame(input vec_t v, input bit dbl);
    int   n;
    bit   seen;
    exp_t e;
    @(negedge clk);
    x_max_1 = v.xa; y_max_1 = v.ya; x_max_2 = v.xb; y_max_2 = v.yb; coords_valid = v.v;
    frame_vsync = 1'b1;
    e.lx = v.lx; e.ly = v.ly; e.rx = v.rx; e.ry = v.ry; e.st = v.st;
    sb_q.push_back(e);
    repeat (3) @(negedge clk);
    frame_vsync = 1'b0;
    if (dbl) begin
      @(negedge clk); frame_vsync = 1'b1;
      @(negedge clk); frame_vsync = 1'b0;
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (frame_done) seen = 1'b1;
    end
    check("frame_done latency", 32'(n), 32'(LATENCY));
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;

    // Phase A: idle frames, acquire, filter steps, hold-out to search, reacquire, hold recovery.
    for (int i = 0; i < 3; i++) vecs_a.push_back(mk(123, 45, 678, 90, 0, 0, 0, 0, 0, 0));
    vecs_a.push_back(mk(900, 310, 400, 300, 1, 400, 300, 900, 310, 1));
    vecs_a.push_back(mk(900, 310, 400, 300, 1, 400, 300, 900, 310, 1));
    vecs_a.push_back(mk(900, 310, 400, 300, 1, 400, 300, 900, 310, 2));
    vecs_a.push_back(mk(900, 310, 440, 300, 1, 410, 300, 900, 310, 2));
    vecs_a.push_back(mk(900, 310, 440, 300, 1, 417, 300, 900, 310, 2));
    vecs_a.push_back(mk(900, 310, 600, 300, 1, 417, 300, 900, 310, 3));
    for (int i = 0; i < 6; i++) vecs_a.push_back(mk(900, 310, 400, 300, 0, 417, 300, 900, 310, 3));
    vecs_a.push_back(mk(900, 310, 400, 300, 0, 0, 0, 0, 0, 0));
    vecs_a.push_back(mk(400, 300, 900, 310, 1, 400, 300, 900, 310, 1));
    vecs_a.push_back(mk(400, 300, 900, 310, 1, 400, 300, 900, 310, 1));
    vecs_a.push_back(mk(400, 300, 900, 310, 1, 400, 300, 900, 310, 2));
    vecs_a.push_back(mk(400, 300, 900, 310, 0, 400, 300, 900, 310, 3));
    vecs_a.push_back(mk(400, 300, 900, 310, 0, 400, 300, 900, 310, 3));
    vecs_a.push_back(mk(420, 300, 900, 310, 1, 405, 300, 900, 310, 2));

    // Phase B (after a mid-frame reset): reload in ACQUIRE, drop to SEARCH, tie sort,
    // jump threshold boundary (64 near, 65 not), negative IIR steps with floor rounding.
    vecs_b.push_back(mk(300, 50, 500, 60, 1, 300, 50, 500, 60, 1));
    vecs_b.push_back(mk(100, 50, 500, 60, 1, 100, 50, 500, 60, 1));
    vecs_b.push_back(mk(100, 50, 500, 60, 0, 0, 0, 0, 0, 0));
    vecs_b.push_back(mk(500, 20, 500, 40, 1, 500, 20, 500, 40, 1));
    vecs_b.push_back(mk(500, 20, 564, 40, 1, 500, 20, 516, 40, 1));
    vecs_b.push_back(mk(500, 20, 581, 40, 1, 500, 20, 581, 40, 1));
    vecs_b.push_back(mk(490, 20, 581, 40, 1, 497, 20, 581, 40, 1));
    vecs_b.push_back(mk(490, 20, 581, 40, 1, 495, 20, 581, 40, 2));
    vecs_b.push_back(mk(490, 20, 581, 40, 1, 494, 20, 581, 40, 2));

    #1;
    check("reset left_x",      32'(left_x),      32'd0);
    check("reset right_x",     32'(right_x),     32'd0);
    check("reset track_state", 32'(track_state), 32'd0);
    check("reset out_valid",   32'(out_valid),   32'd0);
    check("reset frame_done",  32'(frame_done),  32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs_a[i]) drive_frame(vecs_a[i], 1'b0);

    // Out-of-range row while tracking, with a second vsync drop two cycles into the countdown.
    drive_frame(mk(420, 800, 900, 310, 1, 405, 300, 900, 310, 3), 1'b1);
    // x equal to the active width is out of range: second miss, outputs still held.
    drive_frame(mk(1280, 300, 900, 310, 1, 405, 300, 900, 310, 3), 1'b0);

    // Reset asserted mid-countdown: everything returns to zero and the frame never completes.
    @(negedge clk);
    x_max_1 = 11'd410; y_max_1 = 16'd300; coords_valid = 1'b1;
    frame_vsync = 1'b1;
    repeat (3) @(negedge clk);
    frame_vsync = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort left_x",      32'(left_x),      32'd0);
    check("abort right_y",     32'(right_y),     32'd0);
    check("abort track_state", 32'(track_state), 32'd0);
    check("abort out_valid",   32'(out_valid),   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (15) @(negedge clk);
    check("no frame_done after abort", 32'(done_cnt), 32'(d0));

    foreach (vecs_b[i]) drive_frame(vecs_b[i], 1'b0);

    repeat (10) @(negedge clk);
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    check("frame_done count", 32'(done_cnt), 32'(vecs_a.size() + vecs_b.size() + 2));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
